// File: rtl/button_cmd_decoder.sv
// Five-button front panel decoder: synchronise and debounce each button, then drive speed, direction and clear.
// Optional feature macro: AUTO_REPEAT_EN enables auto-repeat of up/down steps while the button stays held.
module button_cmd_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Button_up,
    input  logic       Button_down,
    input  logic       Button_left,
    input  logic       Button_right,
    input  logic       Button_mid,
    output logic [1:0] Sp,
    output logic [1:0] Dir_Sel,
    output logic       Clear
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN_R  = 2'b00,
        RUN_L  = 2'b01,
        HOLD_R = 2'b10,
        HOLD_L = 2'b11
    } state_t;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 mid
    logic [4:0]    raw_s;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_d, deb_dly_q;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];
    logic [3:0]    press_q;
    logic          mid_rel_q;
    logic [LW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          long_evt_s, mid_toggle_s;
    logic          up_s, dn_s, left_s, right_s;
    logic [1:0]    rep_step_s;
    state_t        state_q, state_d;
    logic [1:0]    sp_q, sp_d, dir_q, dir_d;
    logic          clear_q;

    assign raw_s = {Button_mid, Button_right, Button_left, Button_down, Button_up};

    // Debounce counters: clear while synced level matches the accepted level
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Synchronisers, debounced state and registered edge events
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q   <= 5'b00000;
            sync2_q   <= 5'b00000;
            deb_q     <= 5'b00000;
            deb_dly_q <= 5'b00000;
            press_q   <= 4'b0000;
            mid_rel_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q[3:0] & ~deb_dly_q[3:0];
            mid_rel_q <= ~deb_q[4] & deb_dly_q[4];
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Mid hold timer; a long press is latched so its own release is swallowed
    always_comb begin
        long_evt_s   = deb_q[4] & ~long_done_q & (hold_q == LW'(LONG_CYCLES - 1));
        mid_toggle_s = mid_rel_q & ~long_done_q;
        if (!deb_q[4]) begin
            hold_d = '0;
        end else if (!long_done_q) begin
            hold_d = hold_q + LW'(1);
        end else begin
            hold_d = hold_q;
        end
        if (long_evt_s) begin
            long_done_d = 1'b1;
        end else if (mid_rel_q) begin
            long_done_d = 1'b0;
        end else begin
            long_done_d = long_done_q;
        end
    end

    // Hold timer registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];

    // Repeat counters restart at each press and reload after every repeat step
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep_d[i]      = rep_q[i];
            rep_step_s[i] = 1'b0;
            if (press_q[i]) begin
                rep_d[i] = RW'(1);
            end else if (!deb_q[i]) begin
                rep_d[i] = '0;
            end else if (rep_q[i] == RW'(REPEAT_CYCLES)) begin
                rep_d[i]      = RW'(1);
                rep_step_s[i] = 1'b1;
            end else begin
                rep_d[i] = rep_q[i] + RW'(1);
            end
        end
    end

    // Repeat counter registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rep_q[0] <= '0;
            rep_q[1] <= '0;
        end else begin
            rep_q[0] <= rep_d[0];
            rep_q[1] <= rep_d[1];
        end
    end
`else
    assign rep_step_s = 2'b00;
`endif

    assign up_s    = press_q[0] | rep_step_s[0];
    assign dn_s    = press_q[1] | rep_step_s[1];
    assign left_s  = press_q[2];
    assign right_s = press_q[3];

    // Saturating speed; a long mid press forces the slowest speed
    always_comb begin
        if (long_evt_s) begin
            sp_d = 2'b00;
        end else if (up_s && !dn_s && (sp_q != 2'b11)) begin
            sp_d = sp_q + 2'b01;
        end else if (dn_s && !up_s && (sp_q != 2'b00)) begin
            sp_d = sp_q - 2'b01;
        end else begin
            sp_d = sp_q;
        end
    end

    // Direction state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= RUN_R;
        end else begin
            state_q <= state_d;
        end
    end

    // Direction next state: long press, then mid toggle, then left/right
    always_comb begin
        state_d = state_q;
        if (long_evt_s) begin
            state_d = RUN_R;
        end else if (mid_toggle_s) begin
            case (state_q)
                RUN_R:   state_d = HOLD_R;
                HOLD_R:  state_d = RUN_R;
                RUN_L:   state_d = HOLD_L;
                HOLD_L:  state_d = RUN_L;
                default: state_d = RUN_R;
            endcase
        end else if (left_s && !right_s) begin
            state_d = RUN_L;
        end else if (right_s && !left_s) begin
            state_d = RUN_R;
        end else begin
            state_d = state_q;
        end
    end

    // Direction output decode, taken from next state so the register tracks the FSM
    always_comb begin
        case (state_d)
            RUN_R:   dir_d = 2'b01;
            RUN_L:   dir_d = 2'b10;
            default: dir_d = 2'b00;
        endcase
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sp_q    <= 2'b00;
            dir_q   <= 2'b01;
            clear_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dir_q   <= dir_d;
            clear_q <= long_evt_s;
        end
    end

    assign Sp      = sp_q;
    assign Dir_Sel = dir_q;
    assign Clear   = clear_q;

endmodule
